// File: rtl/mole_pkg.sv
// Shared state type and arithmetic helpers for the whack-a-mole field.
// Declarations only: no timing and no flow control of its own.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int life_w(input int life_ticks);
      return $clog2(life_ticks + 1);
   endfunction

   function automatic logic [31:0] popcount(input logic [63:0] v);
      logic [31:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + {31'd0, v[i]};
      end
      return c;
   endfunction

   // Clamps at 2**w-1 instead of wrapping; w must stay below 32.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/mole_slot.sv
// One hole: lifetime counter, up while non-zero; 1-cycle update latency.
// No backpressure: clear beats load beats tick, expire flags the last tick.
module mole_slot
   import mole_pkg::*;
#(
   parameter int LIFE_TICKS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear,
   input  logic tick_en,
   output logic up,
   output logic expire
);

   localparam int LW = life_w(LIFE_TICKS);

   logic [LW-1:0] life_q;
   logic [LW-1:0] life_d;

   always_comb begin
      life_d = life_q;
      if (clear) begin
         life_d = '0;
      end else if (load) begin
         life_d = LW'(LIFE_TICKS);
      end else if (tick_en && up) begin
         life_d = life_q - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         life_q <= '0;
      end else begin
         life_q <= life_d;
      end
   end

   assign up     = (life_q != '0);
   assign expire = tick_en && (life_q == LW'(1));

endmodule

// File: rtl/mole_field.sv
// Multi-mole field: game FSM, spawn timer, spawn arbitration, hit/miss scoring; 1-cycle latency, no backpressure.
// Define MOLE_PENALTY_EN to count hits on empty holes as misses.
module mole_field
   import mole_pkg::*;
#(
   parameter int N_HOLES     = 16,
   parameter int IDX_W       = 4,
   parameter int MAX_ACTIVE  = 3,
   parameter int LIFE_TICKS  = 8,
   parameter int SPAWN_TICKS = 4,
   parameter int SCORE_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         isFinished,
   input  logic                         tick,
   input  logic [IDX_W-1:0]             random_value,
   input  logic [N_HOLES-1:0]           hit,
   output logic [N_HOLES-1:0]           mole,
   output logic [SCORE_W-1:0]           hit_count,
   output logic [SCORE_W-1:0]           miss_count,
   output logic [$clog2(N_HOLES+1)-1:0] active_count,
   output logic                         running
);

   localparam int AC_W = $clog2(N_HOLES + 1);
   localparam int ST_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

   state_t             state_q, state_d;
   logic [ST_W-1:0]    spawn_q, spawn_d;
   logic [SCORE_W-1:0] hit_q, hit_d;
   logic [SCORE_W-1:0] miss_q, miss_d;

   logic               restart;
   logic               run_act;
   logic               tick_en;
   logic               attempt;
   logic               spawn_ok;
   logic [N_HOLES-1:0] sel_v;
   logic [N_HOLES-1:0] hit_v;
   logic [N_HOLES-1:0] miss_v;
   logic [N_HOLES-1:0] pen_v;
   logic [N_HOLES-1:0] load_v;
   logic [N_HOLES-1:0] clear_v;
   logic [N_HOLES-1:0] expire_v;

   for (genvar i = 0; i < N_HOLES; i++) begin : g_slot
      mole_slot #(
         .LIFE_TICKS(LIFE_TICKS)
      ) u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .load   (load_v[i]),
         .clear  (clear_v[i]),
         .tick_en(tick_en),
         .up     (mole[i]),
         .expire (expire_v[i])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)      state_d = RUN;
         RUN:     if (isFinished) state_d = DONE;
         DONE:    if (start)      state_d = RUN;
         default:                 state_d = IDLE;
      endcase
   end

   // isFinished discards everything in its own cycle so the field freezes on the pre-cycle value.
   assign restart = start && (state_q != RUN);
   assign run_act = (state_q == RUN) && !isFinished;
   assign tick_en = run_act && tick;
   assign attempt = tick_en && (spawn_q == ST_W'(SPAWN_TICKS - 1));

   always_comb begin
      sel_v = '0;
      for (int i = 0; i < N_HOLES; i++) begin
         sel_v[i] = (random_value == IDX_W'(i));
      end
   end

   // Occupancy and the active limit use this cycle's field, before hits and expiries land.
   assign spawn_ok = attempt && (|sel_v) && !(|(sel_v & mole))
                     && (active_count < AC_W'(MAX_ACTIVE));
   assign load_v   = spawn_ok ? sel_v : '0;
   assign hit_v    = run_act ? (hit & mole) : '0;
   assign miss_v   = expire_v & ~hit_v;
   assign clear_v  = restart ? '1 : hit_v;

`ifdef MOLE_PENALTY_EN
   assign pen_v = run_act ? (hit & ~mole) : '0;
`else
   assign pen_v = '0;
`endif

   always_comb begin
      spawn_d = spawn_q;
      if (restart) begin
         spawn_d = '0;
      end else if (tick_en) begin
         spawn_d = attempt ? '0 : spawn_q + ST_W'(1);
      end
   end

   // Penalty holes are empty and expiring holes are up, so the two sets never overlap.
   always_comb begin
      hit_d  = hit_q;
      miss_d = miss_q;
      if (restart) begin
         hit_d  = '0;
         miss_d = '0;
      end else begin
         hit_d  = SCORE_W'(sat_add(32'(hit_q), popcount(64'(hit_v)), SCORE_W));
         miss_d = SCORE_W'(sat_add(32'(miss_q), popcount(64'(miss_v | pen_v)), SCORE_W));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         spawn_q <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         spawn_q <= spawn_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   assign hit_count    = hit_q;
   assign miss_count   = miss_q;
   assign active_count = AC_W'(popcount(64'(mole)));
   assign running      = (state_q == RUN);

endmodule

// File: tb/tb_mole_field.sv
// Directed bench: default-parameter field driven from a vector table, plus a small-field
// instance (10 holes, long life, 2-bit scores) for limit, range, saturation and reset cases.
module tb_mole_field;

`ifdef MOLE_PENALTY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start, fin, tick;
   logic [3:0]  rv;
   logic [15:0] hit, mole;
   logic [7:0]  hc, mc;
   logic [4:0]  ac;
   logic        run;

   logic        start2, fin2, tick2;
   logic [3:0]  rv2;
   logic [9:0]  hit2, mole2;
   logic [1:0]  hc2, mc2;
   logic [3:0]  ac2;
   logic        run2;

   mole_field dut (
      .clk(clk), .rst_n(rst_n), .start(start), .isFinished(fin), .tick(tick),
      .random_value(rv), .hit(hit), .mole(mole), .hit_count(hc), .miss_count(mc),
      .active_count(ac), .running(run)
   );

   mole_field #(
      .N_HOLES(10), .IDX_W(4), .MAX_ACTIVE(3), .LIFE_TICKS(32), .SPAWN_TICKS(4), .SCORE_W(2)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .isFinished(fin2), .tick(tick2),
      .random_value(rv2), .hit(hit2), .mole(mole2), .hit_count(hc2), .miss_count(mc2),
      .active_count(ac2), .running(run2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int row, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", nm, row, a, e);
      end
   endtask

   typedef struct {
      logic        start;
      logic        fin;
      logic        tick;
      logic [3:0]  rv;
      logic [15:0] hit;
      logic [15:0] e_mole;
      int          e_hit;
      int          e_miss;
      int          e_act;
      logic        e_run;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic s, input logic f, input logic t, input logic [3:0] r,
                      input logic [15:0] h, input logic [15:0] m,
                      input int eh, input int em, input int ea, input logic er);
      vec_t v;
      v.start = s; v.fin = f; v.tick = t; v.rv = r; v.hit = h;
      v.e_mole = m; v.e_hit = eh; v.e_miss = em; v.e_act = ea; v.e_run = er;
      tbl.push_back(v);
   endtask

   task automatic step2(input logic s, input logic t, input logic [3:0] r, input logic [9:0] h);
      start2 = s; tick2 = t; rv2 = r; hit2 = h;
      @(posedge clk);
      #1;
      start2 = 1'b0; tick2 = 1'b0; hit2 = '0;
   endtask

   // Four ticks spaced four cycles apart; the candidate matters on the last one.
   task automatic attempt2(input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         step2(1'b0, 1'b1, r, '0);
         repeat (3) step2(1'b0, 1'b0, r, '0);
      end
   endtask

   task automatic chk2(input string nm, input logic [9:0] m, input int a, input int h);
      chk({nm, ".mole"}, 0, 64'(mole2), 64'(m));
      chk({nm, ".active"}, 0, 64'(ac2), 64'(a));
      chk({nm, ".hits"}, 0, 64'(hc2), 64'(h));
   endtask

   initial begin
      start = 0; fin = 0; tick = 0; rv = 0; hit = 0;
      start2 = 0; fin2 = 0; tick2 = 0; rv2 = 0; hit2 = 0;

      // Hand-computed schedule: attempts fall on ticks 4, 8, 12, ...; life is 8 ticks.
      add(1, 0, 0, 5, 0, 16'h0000, 0, 0, 0, 1);
      for (int i = 1; i <= 3; i++)  add(0, 0, 1, 5, 0, 16'h0000, 0, 0, 0, 1);
      for (int i = 4; i <= 11; i++) add(0, 0, 1, 5, 0, 16'h0020, 0, 0, 1, 1);
      for (int i = 12; i <= 15; i++) add(0, 0, 1, 5, 0, 16'h0000, 0, 1, 0, 1);
      add(0, 0, 1, 5, 0, 16'h0020, 0, 1, 1, 1);
      add(0, 0, 0, 5, 16'h0020, 16'h0000, 1, 1, 0, 1);
      add(0, 0, 0, 5, 16'h0020, 16'h0000, 1, 1 + P, 0, 1);
      for (int i = 17; i <= 19; i++) add(0, 0, 1, 5, 0, 16'h0000, 1, 1 + P, 0, 1);
      for (int i = 20; i <= 27; i++) add(0, 0, 1, 5, 0, 16'h0020, 1, 1 + P, 1, 1);
      add(0, 0, 1, 9, 16'h0020, 16'h0200, 2, 1 + P, 1, 1);
      add(0, 0, 0, 9, 16'h0200, 16'h0000, 3, 1 + P, 0, 1);
      for (int i = 29; i <= 31; i++) add(0, 0, 1, 2, 0, 16'h0000, 3, 1 + P, 0, 1);
      add(0, 0, 1, 2, 0, 16'h0004, 3, 1 + P, 1, 1);
      for (int i = 33; i <= 35; i++) add(0, 0, 1, 8, 0, 16'h0004, 3, 1 + P, 1, 1);
      add(0, 0, 1, 8, 0, 16'h0104, 3, 1 + P, 2, 1);
      add(0, 1, 1, 3, 16'h0004, 16'h0104, 3, 1 + P, 2, 0);
      add(0, 0, 1, 3, 16'h0100, 16'h0104, 3, 1 + P, 2, 0);
      add(0, 1, 1, 3, 16'h0004, 16'h0104, 3, 1 + P, 2, 0);
      add(1, 0, 0, 3, 0, 16'h0000, 0, 0, 0, 1);
      add(1, 0, 1, 3, 0, 16'h0000, 0, 0, 0, 1);

      #12;
      chk("rst.mole", 0, 64'(mole), 64'h0);
      chk("rst.hits", 0, 64'(hc), 64'h0);
      chk("rst.miss", 0, 64'(mc), 64'h0);
      chk("rst.active", 0, 64'(ac), 64'h0);
      chk("rst.running", 0, 64'(run), 64'h0);
      chk("rst.running2", 0, 64'(run2), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         start = tbl[i].start; fin = tbl[i].fin; tick = tbl[i].tick;
         rv = tbl[i].rv; hit = tbl[i].hit;
         @(posedge clk);
         #1;
         chk("mole", i, 64'(mole), 64'(tbl[i].e_mole));
         chk("hit_count", i, 64'(hc), 64'(tbl[i].e_hit));
         chk("miss_count", i, 64'(mc), 64'(tbl[i].e_miss));
         chk("active_count", i, 64'(ac), 64'(tbl[i].e_act));
         chk("running", i, 64'(run), 64'(tbl[i].e_run));
      end
      start = 0; fin = 0; tick = 0; hit = 0;

      // Small field: active limit, out-of-range and occupied candidates, saturation.
      step2(1'b1, 1'b0, 4'd0, '0);
      chk("f2.running", 0, 64'(run2), 64'h1);
      attempt2(4'd1);  chk2("f2.spawn1", 10'h002, 1, 0);
      attempt2(4'd2);  chk2("f2.spawn2", 10'h006, 2, 0);
      attempt2(4'd3);  chk2("f2.spawn3", 10'h00E, 3, 0);
      attempt2(4'd4);  chk2("f2.limit", 10'h00E, 3, 0);
      step2(1'b0, 1'b0, 4'd0, 10'h002);
      chk2("f2.hit1", 10'h00C, 2, 1);
      attempt2(4'd12); chk2("f2.range", 10'h00C, 2, 1);
      attempt2(4'd2);  chk2("f2.occupied", 10'h00C, 2, 1);
      attempt2(4'd9);  chk2("f2.spawn9", 10'h20C, 3, 1);
      step2(1'b0, 1'b0, 4'd0, 10'h20C);
      chk2("f2.sat", 10'h000, 0, 3);
      chk("f2.miss", 0, 64'(mc2), 64'h0);
      attempt2(4'd0);  chk2("f2.spawn0", 10'h001, 1, 3);
      step2(1'b0, 1'b0, 4'd0, 10'h001);
      chk2("f2.nowrap", 10'h000, 0, 3);
      attempt2(4'd7);  chk2("f2.spawn7", 10'h080, 1, 3);

      // Reset dropped between clock edges must clear outputs without waiting for an edge.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk2("f2.arst", 10'h000, 0, 0);
      chk("f2.arst.miss", 0, 64'(mc2), 64'h0);
      chk("f2.arst.running", 0, 64'(run2), 64'h0);
      chk("arst.running", 0, 64'(run), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      attempt2(4'd3);
      chk2("f2.idle", 10'h000, 0, 0);
      chk("f2.idle.running", 0, 64'(run2), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
